// File: rtl/eq_pkg.sv
// Shared defaults for the eq_inferencia equality comparator.
package eq_pkg;

    localparam int EQ_W_DEF     = 2;
    localparam int EQ_CNT_W_DEF = 16;

endpackage : eq_pkg

// File: rtl/eq_bit1.sv
// Single-bit equality cell: high when both inputs are equal.
module eq_bit1 (
    input  logic i1,
    input  logic i2,
    output logic eq
);

    assign eq = (~i1 & ~i2) | (i1 & i2);

endmodule : eq_bit1

// File: rtl/eq_inferencia.sv
// W-bit equality comparator with registered result, match counter and mismatch flag.
// Optional macro EQ_INFERENCIA_MAGNITUDE_EN adds unsigned agtb/altb outputs.
module eq_inferencia
    import eq_pkg::*;
#(
    parameter int W     = EQ_W_DEF,
    parameter int CNT_W = EQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             in_valid,
    input  logic             clr,
    output logic             aeqb,
    output logic             eq_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] match_cnt,
    output logic             mismatch_sticky
`ifdef EQ_INFERENCIA_MAGNITUDE_EN
    ,
    output logic             agtb,
    output logic             altb
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W-1:0]     w_bit_eq;
    logic             r_eq_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_mismatch_sticky;

    for (genvar g = 0; g < W; g++) begin : g_bit
        eq_bit1 u_eq_bit1 (
            .i1 (a[g]),
            .i2 (b[g]),
            .eq (w_bit_eq[g])
        );
    end

    assign aeqb = &w_bit_eq;

    // eq_q only loads on a valid sample; otherwise it holds the last result.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eq_q      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_eq_q <= aeqb;
            end
        end
    end

    // clr wins over the same-cycle sample, so that sample is never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match_cnt       <= '0;
            r_mismatch_sticky <= 1'b0;
        end else if (clr) begin
            r_match_cnt       <= '0;
            r_mismatch_sticky <= 1'b0;
        end else if (in_valid) begin
            if (aeqb) begin
                if (r_match_cnt != CNT_MAX) begin
                    r_match_cnt <= r_match_cnt + 1'b1;
                end
            end else begin
                r_mismatch_sticky <= 1'b1;
            end
        end
    end

    assign eq_q            = r_eq_q;
    assign out_valid       = r_out_valid;
    assign match_cnt       = r_match_cnt;
    assign mismatch_sticky = r_mismatch_sticky;

`ifdef EQ_INFERENCIA_MAGNITUDE_EN
    assign agtb = (a > b);
    assign altb = (a < b);
`endif

endmodule : eq_inferencia

// File: tb/tb_eq_inferencia.sv
// Directed self-checking bench for eq_inferencia with an expected-result queue.
module tb_eq_inferencia;

    localparam int W     = 2;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             in_valid;
    logic             clr;
    logic             aeqb;
    logic             eq_q;
    logic             out_valid;
    logic [CNT_W-1:0] match_cnt;
    logic             mismatch_sticky;
`ifdef EQ_INFERENCIA_MAGNITUDE_EN
    logic             agtb;
    logic             altb;
`endif

    eq_inferencia #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a               (a),
        .b               (b),
        .in_valid        (in_valid),
        .clr             (clr),
        .aeqb            (aeqb),
        .eq_q            (eq_q),
        .out_valid       (out_valid),
        .match_cnt       (match_cnt),
        .mismatch_sticky (mismatch_sticky)
`ifdef EQ_INFERENCIA_MAGNITUDE_EN
        ,
        .agtb            (agtb),
        .altb            (altb)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bit exp_q[$];
    int m_cnt;
    bit m_sticky;
    bit m_eq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_sticky = 1'b0;
        m_eq     = 1'b0;
        exp_q.delete();
    endtask

    // Drives one cycle of stimulus, updates the model, then checks registered outputs after the edge.
    task automatic cycle(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic v, input logic c, input string tag);
        a        = ta;
        b        = tb_v;
        in_valid = v;
        clr      = c;
        if (c) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else if (v) begin
            if (ta == tb_v) begin
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_sticky = 1'b1;
            end
        end
        if (v) exp_q.push_back(ta == tb_v);
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd1, 32'd0);
            else m_eq = exp_q.pop_front();
        end
        check({tag, "_eq_q"}, {31'd0, eq_q}, {31'd0, m_eq});
        check({tag, "_match_cnt"}, {{(32-CNT_W){1'b0}}, match_cnt}, m_cnt);
        check({tag, "_sticky"}, {31'd0, mismatch_sticky}, {31'd0, m_sticky});
    endtask

    logic [W-1:0] va [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
    logic [W-1:0] vb [5] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
    logic         ve [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        reset    = 1'b1;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        clr      = 1'b0;
        model_reset();

        // Reset state before any clock edge
        #3;
        check("rst_eq_q", {31'd0, eq_q}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_match_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        check("rst_sticky", {31'd0, mismatch_sticky}, 32'd0);
        check("rst_aeqb_live", {31'd0, aeqb}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Combinational equality over the directed pairs
        for (int i = 0; i < 5; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            check($sformatf("aeqb_%0d", i), {31'd0, aeqb}, {31'd0, ve[i]});
        end

        // Registered path, one valid cycle per pair
        for (int i = 0; i < 5; i++) begin
            cycle(va[i], vb[i], 1'b1, 1'b0, $sformatf("pair_%0d", i));
            check($sformatf("pair_%0d_table", i), {31'd0, eq_q}, {31'd0, ve[i]});
        end
        check("after_pairs_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd3);
        check("after_pairs_sticky", {31'd0, mismatch_sticky}, 32'd1);

        // Idle cycles: eq_q holds, out_valid drops
        cycle(2'b01, 2'b10, 1'b0, 1'b0, "idle0");
        cycle(2'b00, 2'b11, 1'b0, 1'b0, "idle1");

        // clr with a valid unequal sample, then with a valid equal sample
        cycle(2'b01, 2'b00, 1'b1, 1'b1, "clr_unequal");
        check("clr_unequal_cnt0", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        check("clr_unequal_sticky0", {31'd0, mismatch_sticky}, 32'd0);
        cycle(2'b10, 2'b10, 1'b1, 1'b1, "clr_equal");

        // Saturation: preload to max-1, then three more equal samples
        for (int i = 0; i < CNT_MAX - 1; i++) begin
            cycle(W'(i), W'(i), 1'b1, 1'b0, $sformatf("fill_%0d", i));
        end
        check("preload", {{(32-CNT_W){1'b0}}, match_cnt}, CNT_MAX - 1);
        for (int i = 0; i < 3; i++) begin
            cycle(2'b11, 2'b11, 1'b1, 1'b0, $sformatf("sat_%0d", i));
        end
        check("saturated", {{(32-CNT_W){1'b0}}, match_cnt}, CNT_MAX);

        // Reset mid-stream, between clock edges
        cycle(2'b01, 2'b10, 1'b1, 1'b0, "pre_reset");
        a        = 2'b11;
        b        = 2'b11;
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_eq_q", {31'd0, eq_q}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_match_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        check("midrst_sticky", {31'd0, mismatch_sticky}, 32'd0);
        check("midrst_aeqb", {31'd0, aeqb}, 32'd1);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_cnt", {{(32-CNT_W){1'b0}}, match_cnt}, 32'd0);
        cycle(2'b10, 2'b10, 1'b1, 1'b0, "first_after_rst");
        cycle(2'b10, 2'b00, 1'b0, 1'b0, "drain_after_rst");

`ifdef EQ_INFERENCIA_MAGNITUDE_EN
        a = 2'b10;
        b = 2'b01;
        #1;
        check("mag_gt_agtb", {31'd0, agtb}, 32'd1);
        check("mag_gt_altb", {31'd0, altb}, 32'd0);
        check("mag_gt_aeqb", {31'd0, aeqb}, 32'd0);
        a = 2'b01;
        b = 2'b11;
        #1;
        check("mag_lt_altb", {31'd0, altb}, 32'd1);
        check("mag_lt_agtb", {31'd0, agtb}, 32'd0);
        a = 2'b11;
        b = 2'b11;
        #1;
        check("mag_eq_agtb", {31'd0, agtb}, 32'd0);
        check("mag_eq_altb", {31'd0, altb}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_eq_inferencia

// File: doc/eq_inferencia.md
EQ_INFERENCIA -- requirements
Module: eq_inferencia

Interface
REQ-001 The block SHALL have parameter W, default 2, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the match-counter width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port a, input, W bits: operand A, unsigned.
REQ-006 Port b, input, W bits: operand B, unsigned.
REQ-007 Port in_valid, input, 1 bit: qualifies a and b for the registered path.
REQ-008 Port clr, input, 1 bit: synchronous clear of the statistics.
REQ-009 Port aeqb, output, 1 bit: combinational equality flag, high when a equals b.
REQ-010 Port eq_q, output, 1 bit: registered equality result.
REQ-011 Port out_valid, output, 1 bit: qualifies eq_q.
REQ-012 Port match_cnt, output, CNT_W bits: count of valid equal samples.
REQ-013 Port mismatch_sticky, output, 1 bit: sticky flag, set by any valid unequal sample.

Function
REQ-014 aeqb SHALL equal 1 exactly when every bit of a matches the corresponding bit of b, with zero latency and independent of in_valid, clk and reset.
REQ-015 aeqb SHALL be formed as the AND of W per-bit equality cells.
REQ-016 Each per-bit cell SHALL compute (~i1 & ~i2) | (i1 & i2).
REQ-017 When in_valid=1 at a clock edge, eq_q SHALL take the value of aeqb and out_valid SHALL be 1 for the following cycle (latency 1).
REQ-018 When in_valid=0 at a clock edge, out_valid SHALL go to 0 and eq_q SHALL hold its value.
REQ-019 When in_valid=1 and aeqb=1 at a clock edge, match_cnt SHALL increment by 1.
REQ-020 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 When in_valid=1 and aeqb=0 at a clock edge, mismatch_sticky SHALL be set to 1; it SHALL remain 1 until clr or reset.
REQ-022 When clr=1 at a clock edge, match_cnt SHALL be set to 0 and mismatch_sticky to 0.
REQ-023 clr SHALL take priority over any increment or set in the same cycle; that cycle's sample SHALL NOT be counted.
REQ-024 clr SHALL NOT affect eq_q or out_valid.
REQ-025 X or Z values on a or b SHALL NOT be specially handled.

Reset
REQ-026 While reset=1, eq_q, out_valid, match_cnt and mismatch_sticky SHALL all be 0 immediately, without waiting for a clock edge.
REQ-027 Reset asserted in the middle of a transaction SHALL discard that transaction.
REQ-028 The first in_valid accepted after reset deasserts SHALL produce out_valid one cycle later.
REQ-029 aeqb SHALL remain combinationally valid during reset.

Configuration
REQ-030 When macro EQ_INFERENCIA_MAGNITUDE_EN is defined, the block SHALL add combinational outputs agtb and altb, each 1 bit.
REQ-031 agtb SHALL be 1 when a>b unsigned, and altb SHALL be 1 when a<b unsigned; exactly one of aeqb, agtb, altb SHALL be 1 at any time.
REQ-032 When EQ_INFERENCIA_MAGNITUDE_EN is not defined, agtb and altb SHALL NOT exist as ports and no magnitude logic SHALL be built.

Structure
REQ-033 Shared package eq_pkg SHALL hold the default constants EQ_W_DEF=2 and EQ_CNT_W_DEF=16.
REQ-034 The per-bit equality cell SHALL be the sub-module eq_bit1 (ports i1, i2, eq), instantiated W times through a generate loop.

Verification
REQ-035 With W=2: a=00,b=00 gives aeqb=1; a=01,b=00 gives 0; a=00,b=10 gives 0; a=10,b=10 gives 1; a=11,b=11 gives 1.
REQ-036 Same five pairs, each with in_valid=1 for one cycle: eq_q sequence 1,0,0,1,1 with out_valid=1 one cycle after each; afterwards match_cnt=3 and mismatch_sticky=1.
REQ-037 Preload match_cnt to 2^CNT_W-2, then apply three valid equal samples: match_cnt ends at 2^CNT_W-1 and holds there.
REQ-038 clr=1 in the same cycle as a valid unequal sample: mismatch_sticky=0 and match_cnt=0 on the next cycle.
REQ-039 Assert reset between clock edges during a stream: all registered outputs go to 0 at once, before the next clock edge.
REQ-040 With EQ_INFERENCIA_MAGNITUDE_EN defined: a=10,b=01 gives agtb=1, altb=0, aeqb=0; a=01,b=11 gives altb=1.
